// File: rtl/core_if_pkg.sv
// rtl/core_if_pkg.sv - shared widths and opcodes for the core register interface
package core_if_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 24;
    localparam int OPCODE_W = 8;

    localparam logic [OPCODE_W-1:0] OP_NOP        = 8'h00;
    localparam logic [OPCODE_W-1:0] OP_WRITE      = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_READ       = 8'h02;
    localparam logic [OPCODE_W-1:0] OP_BIND_READ  = 8'h03;
    localparam logic [OPCODE_W-1:0] OP_BIND_WRITE = 8'h04;
    localparam logic [OPCODE_W-1:0] OP_STREAM     = 8'h05;

endpackage

// File: rtl/core_register_interface_if.sv
// rtl/core_register_interface_if.sv - host command/result bundle for the core register interface
interface core_register_interface_if;
    import core_if_pkg::*;

    logic [OPCODE_W-1:0] instruction;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   value;
    logic [DATA_W-1:0]   result;
    logic [DATA_W-1:0]   stream;

    modport master (output instruction, address, value, input result, stream);
    modport slave  (input instruction, address, value, output result, stream);

endinterface

// File: rtl/core_register_interface_adder_core.sv
// rtl/core_register_interface_adder_core.sv - reference compute core: 32-bit wrapping adder
module adder_core (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] c_o
);

    // Carry out is intentionally dropped; the sum wraps modulo 2^32.
    assign c_o = a_i + b_i;

endmodule

// File: rtl/core_register_interface.sv
// rtl/core_register_interface.sv - memory-mapped register wrapper around a compute core
module core_register_interface
    import core_if_pkg::*;
#(
    parameter int TOTAL_INPUTS  = 2,
    parameter int TOTAL_OUTPUTS = 1,
    parameter int START_ADDRESS = 0,
    parameter int END_ADDRESS   = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    core_register_interface_if.slave  bus
);

    localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDRESS);
    localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(END_ADDRESS - START_ADDRESS);
    localparam logic [ADDR_W-1:0] N_INPUTS  = ADDR_W'(TOTAL_INPUTS);
    localparam logic [ADDR_W-1:0] FIRST_OUT = ADDR_W'(START_ADDRESS + TOTAL_INPUTS);

    logic [DATA_W-1:0] input_reg_q [TOTAL_INPUTS];
    logic [DATA_W-1:0] input_reg_d [TOTAL_INPUTS];
    logic [DATA_W-1:0] core_out    [TOTAL_OUTPUTS];
    logic [DATA_W-1:0] core_sum;
    logic [ADDR_W-1:0] read_bind_q, read_bind_d;
    logic [ADDR_W-1:0] write_bind_q, write_bind_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] stream_q, stream_d;

    // Offsets from the window base; addresses below the base wrap to huge
    // values, so a single unsigned compare gives an exact 24-bit range check.
    logic [ADDR_W-1:0] addr_off, rbind_off, wbind_off;
    logic              addr_is_input, addr_in_range;
    logic [DATA_W-1:0] addr_word, bind_word;

    assign addr_off      = bus.address - START_A;
    assign rbind_off     = read_bind_q - START_A;
    assign wbind_off     = write_bind_q - START_A;
    assign addr_is_input = addr_off < N_INPUTS;
    assign addr_in_range = addr_off <= SPAN;

    adder_core u_core (
        .a_i (input_reg_q[0]),
        .b_i (input_reg_q[1]),
        .c_o (core_sum)
    );

    // Core output words as seen through the address map.
    always_comb begin
        for (int k = 0; k < TOTAL_OUTPUTS; k++) begin
            core_out[k] = '0;
        end
        core_out[0] = core_sum;
    end

    // Word visible at a window offset; anything outside the window reads 0.
    function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] off);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < TOTAL_INPUTS; i++) begin
            if (off == ADDR_W'(i)) w = input_reg_q[i];
        end
        for (int j = 0; j < TOTAL_OUTPUTS; j++) begin
            if (off == ADDR_W'(TOTAL_INPUTS + j)) w = core_out[j];
        end
        return w;
    endfunction

    // Read ports use pre-edge state so STREAM is read-before-write.
    always_comb begin
        addr_word = word_at(addr_off);
        bind_word = word_at(rbind_off);
    end

    // Opcode decode: compute next state of every register, holding by default.
    always_comb begin
        input_reg_d  = input_reg_q;
        read_bind_d  = read_bind_q;
        write_bind_d = write_bind_q;
        result_d     = result_q;
        stream_d     = stream_q;
        case (bus.instruction)
            OP_WRITE: begin
                for (int i = 0; i < TOTAL_INPUTS; i++) begin
                    if (addr_is_input && addr_off == ADDR_W'(i)) input_reg_d[i] = bus.value;
                end
            end
            OP_READ: begin
                result_d = addr_word;
            end
            OP_BIND_READ: begin
                if (addr_in_range) read_bind_d = bus.address;
            end
            OP_BIND_WRITE: begin
                if (addr_is_input) write_bind_d = bus.address;
            end
            OP_STREAM: begin
                for (int i = 0; i < TOTAL_INPUTS; i++) begin
                    if (wbind_off == ADDR_W'(i)) input_reg_d[i] = bus.value;
                end
                result_d = bind_word;
                stream_d = bind_word;
            end
            default: begin
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TOTAL_INPUTS; i++) begin
                input_reg_q[i] <= '0;
            end
            read_bind_q  <= FIRST_OUT;
            write_bind_q <= START_A;
            result_q     <= '0;
            stream_q     <= '0;
        end else begin
            input_reg_q  <= input_reg_d;
            read_bind_q  <= read_bind_d;
            write_bind_q <= write_bind_d;
            result_q     <= result_d;
            stream_q     <= stream_d;
        end
    end

    assign bus.result = result_q;
    assign bus.stream = stream_q;

endmodule

// File: tb/tb_core_register_interface.sv
// tb/tb_core_register_interface.sv - self-checking bench for core_register_interface
module tb_core_register_interface;

    logic clk_i;
    logic rst_ni;
    int   checks;
    int   errors;

    core_register_interface_if bus ();

    core_register_interface #(
        .TOTAL_INPUTS  (2),
        .TOTAL_OUTPUTS (1),
        .START_ADDRESS (0),
        .END_ADDRESS   (2)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference state: two inputs at addresses 0 and 1, their sum at address 2.
    logic [31:0] m_in [2];
    logic [31:0] m_res;
    logic [31:0] m_str;
    logic [23:0] m_rb;
    logic [23:0] m_wb;

    function automatic logic [31:0] m_read(input logic [23:0] a);
        if (a == 24'd0) return m_in[0];
        if (a == 24'd1) return m_in[1];
        if (a == 24'd2) return m_in[0] + m_in[1];
        return 32'd0;
    endfunction

    task automatic m_reset();
        m_in[0] = 0;
        m_in[1] = 0;
        m_res   = 0;
        m_str   = 0;
        m_rb    = 24'd2;
        m_wb    = 24'd0;
    endtask

    task automatic m_apply(input logic [7:0] op, input logic [23:0] a, input logic [31:0] v);
        logic [31:0] w;
        case (op)
            8'h01: if (a < 24'd2) m_in[a[0]] = v;
            8'h02: m_res = m_read(a);
            8'h03: if (a <= 24'd2) m_rb = a;
            8'h04: if (a < 24'd2) m_wb = a;
            8'h05: begin
                w = m_read(m_rb);
                m_in[m_wb[0]] = v;
                m_res = w;
                m_str = w;
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one instruction, let one edge pass, compare against the model.
    task automatic step(input logic [7:0] op, input logic [23:0] a, input logic [31:0] v);
        bus.instruction = op;
        bus.address     = a;
        bus.value       = v;
        @(posedge clk_i);
        m_apply(op, a, v);
        #1;
        chk("model_result", bus.result, m_res);
        chk("model_stream", bus.stream, m_str);
    endtask

    logic [7:0]  r_op;
    logic [23:0] r_a;
    logic [31:0] r_v;

    initial begin
        checks = 0;
        errors = 0;
        m_reset();
        rst_ni = 1'b0;
        bus.instruction = 8'h00;
        bus.address     = '0;
        bus.value       = '0;

        // Reset held: random traffic must not disturb the cleared outputs.
        for (int i = 0; i < 6; i++) begin
            bus.instruction = 8'($urandom_range(0, 5));
            bus.address     = 24'($urandom_range(0, 3));
            bus.value       = $urandom;
            @(posedge clk_i);
            #1;
            chk("reset_result", bus.result, 32'd0);
            chk("reset_stream", bus.stream, 32'd0);
        end
        rst_ni = 1'b1;
        step(8'h02, 24'd2, 32'd0);
        chk("post_reset_sum", bus.result, 32'd0);

        // Basic write / read of inputs and the sum.
        step(8'h01, 24'd0, 32'd5);
        step(8'h01, 24'd1, 32'd7);
        step(8'h02, 24'd2, 32'd0);
        chk("sum_5_7", bus.result, 32'd12);
        step(8'h02, 24'd0, 32'd0);
        chk("read_in0", bus.result, 32'd5);
        step(8'h02, 24'd1, 32'd0);
        chk("read_in1", bus.result, 32'd7);

        // Wraparound, ignored output write, out-of-range read.
        step(8'h01, 24'd0, 32'hFFFF_FFFF);
        step(8'h01, 24'd1, 32'd2);
        step(8'h02, 24'd2, 32'd0);
        chk("sum_wrap", bus.result, 32'd1);
        step(8'h01, 24'd2, 32'd99);
        step(8'h02, 24'd2, 32'd0);
        chk("write_out_ignored", bus.result, 32'd1);
        step(8'h02, 24'd3, 32'd0);
        chk("read_oor", bus.result, 32'd0);
        step(8'h02, 24'h000100, 32'd0);
        chk("read_no_alias", bus.result, 32'd0);

        // Bound streaming with read-before-write.
        step(8'h01, 24'd1, 32'd10);
        step(8'h04, 24'd0, 32'd0);
        step(8'h03, 24'd2, 32'd0);
        step(8'h05, 24'd0, 32'd3);
        chk("stream_pre_edge", bus.stream, 32'hFFFF_FFFF + 32'd10);
        step(8'h05, 24'd0, 32'd4);
        chk("stream_13", bus.stream, 32'd13);
        chk("stream_result_13", bus.result, 32'd13);
        step(8'h00, 24'd0, 32'd0);
        chk("nop_hold", bus.stream, 32'd13);
        step(8'h02, 24'd2, 32'd0);
        chk("sum_after_stream", bus.result, 32'd14);
        chk("read_keeps_stream", bus.stream, 32'd13);

        // Undefined opcode is a NOP.
        step(8'hFF, 24'd0, 32'd42);
        step(8'h02, 24'd0, 32'd0);
        chk("bad_opcode", bus.result, 32'd4);

        // Async reset between two writes, asserted away from the clock edge.
        step(8'h01, 24'd0, 32'd77);
        rst_ni = 1'b0;
        #1;
        m_reset();
        chk("async_clear_result", bus.result, 32'd0);
        chk("async_clear_stream", bus.stream, 32'd0);
        #1;
        rst_ni = 1'b1;
        step(8'h01, 24'd1, 32'd6);
        step(8'h02, 24'd2, 32'd0);
        chk("post_reset_write_only", bus.result, 32'd6);
        step(8'h02, 24'd0, 32'd0);
        chk("post_reset_in0", bus.result, 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       r_op = 8'($urandom);
                default: r_op = 8'($urandom_range(0, 5));
            endcase
            case ($urandom_range(0, 5))
                0:       r_a = 24'($urandom);
                1:       r_a = 24'hFFFFFF;
                default: r_a = 24'($urandom_range(0, 3));
            endcase
            r_v = $urandom;
            step(r_op, r_a, r_v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
